// File: rtl/any1_wb_mem_model.sv
// Wishbone classic slave memory for ANY-1 simulation and bring-up: byte-writable RAM,
// preloadable ROM, fill word for unmapped reads, per-transfer wait states and error replies.
module any1_wb_mem_model #(
  parameter int unsigned     DWID      = 128,
  parameter int unsigned     AWID      = 32,
  parameter int unsigned     RAM_WORDS = 1024,
  parameter int unsigned     ROM_WORDS = 64,
  parameter logic [7:0]      ROM_SEL   = 8'hFF,
  parameter logic [31:0]     NOP_INSN  = 32'h0000_00FF,
  parameter logic [DWID-1:0] FILL_WORD = {(DWID / 32){NOP_INSN}}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cyc_i,
  input  logic                         stb_i,
  input  logic                         we_i,
  input  logic [DWID/8-1:0]            sel_i,
  input  logic [AWID-1:0]              adr_i,
  input  logic [DWID-1:0]              dat_i,
  input  logic [3:0]                   wait_i,
  output logic                         ack_o,
  output logic                         err_o,
  output logic [DWID-1:0]              dat_o,
  input  logic                         rom_we_i,
  input  logic [$clog2(ROM_WORDS)-1:0] rom_adr_i,
  input  logic [DWID-1:0]              rom_dat_i
);

  localparam int unsigned NBYTE  = DWID / 8;
  localparam int unsigned LSB    = $clog2(NBYTE);
  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
  localparam int unsigned WCNT_W = 4;
  localparam logic [AWID:0] RAM_LIMIT = (AWID + 1)'(RAM_WORDS * NBYTE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AWID-1:0]     adr_q, adr_d;
  logic                we_q, we_d;
  logic [NBYTE-1:0]    sel_q, sel_d;
  logic [DWID-1:0]     wdat_q, wdat_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DWID-1:0]     rdat_q, rdat_d;

  logic [DWID-1:0]     ram_mem [RAM_WORDS];
  logic [DWID-1:0]     rom_mem [ROM_WORDS];

  logic                x_we;
  logic [NBYTE-1:0]    x_sel;
  logic [AWID-1:0]     x_adr;
  logic [DWID-1:0]     x_dat;
  logic                rom_hit;
  logic                ram_hit;
  logic [RAM_AW-1:0]   ram_idx;
  logic [ROM_AW-1:0]   rom_idx;
  logic                respond;
  logic                ram_we;

  // A zero-wait transfer responds straight from IDLE, so use live bus values there.
  always_comb begin
    x_we  = (state_q == S_IDLE) ? we_i  : we_q;
    x_sel = (state_q == S_IDLE) ? sel_i : sel_q;
    x_adr = (state_q == S_IDLE) ? adr_i : adr_q;
    x_dat = (state_q == S_IDLE) ? dat_i : wdat_q;
  end

  always_comb begin
    rom_hit = (x_adr[AWID-1 -: 8] == ROM_SEL);
    ram_hit = !rom_hit && ({1'b0, x_adr} < RAM_LIMIT);
    ram_idx = x_adr[LSB +: RAM_AW];
    rom_idx = x_adr[LSB +: ROM_AW];
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    wcnt_d  = wcnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    respond = 1'b0;
    ram_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d  = adr_i;
          we_d   = we_i;
          sel_d  = sel_i;
          wdat_d = dat_i;
          wcnt_d = wait_i;
          if (wait_i == '0) begin
            respond = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else if (wcnt_q <= WCNT_W'(1)) begin
          wcnt_d  = '0;
          respond = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_RESP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response is decided on the edge entering RESP so ack/err/dat are registered.
    if (respond) begin
      if (x_we) begin
        if (ram_hit) begin
          ack_d  = 1'b1;
          ram_we = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        ack_d = 1'b1;
        if (rom_hit)      rdat_d = rom_mem[rom_idx];
        else if (ram_hit) rdat_d = ram_mem[ram_idx];
        else              rdat_d = FILL_WORD;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage is not reset; a write pending when reset hits is dropped.
  always_ff @(posedge clk_i) begin
    if (ram_we && !rst_i) begin
      for (int b = 0; b < int'(NBYTE); b++) begin
        if (x_sel[b]) ram_mem[ram_idx][8*b +: 8] <= x_dat[8*b +: 8];
      end
    end
    if (rom_we_i) rom_mem[rom_adr_i] <= rom_dat_i;
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = rdat_q;

endmodule
